sine_dds_gen: RTL

//  Parametrised direct-digital-synthesis sine/cosine generator. A phase accumulator

---
 rtl/sine_dds_gen_if.sv | 24 ++
 rtl/sine_dds_gen.sv | 126 ++++++++++++
 2 files changed

// File: rtl/sine_dds_gen_if.sv
// Control and sample bus of the sine/cosine DDS: tuning inputs in, signed samples out.
// out_valid is a valid-only strobe: one sample per cycle, no ready, the consumer takes it that cycle.
interface sine_dds_gen_if #(
   parameter int PHASE_W = 32,
   parameter int DATA_W  = 16
);
   logic                     en;
   logic                     phase_clr;
   logic [PHASE_W-1:0]       freq_word;
   logic [PHASE_W-1:0]       phase_ofs;
   logic signed [DATA_W-1:0] sin_out;
   logic signed [DATA_W-1:0] cos_out;
   logic                     out_valid;

   modport master (
      output en, phase_clr, freq_word, phase_ofs,
      input  sin_out, cos_out, out_valid
   );

   modport slave (
      input  en, phase_clr, freq_word, phase_ofs,
      output sin_out, cos_out, out_valid
   );
endinterface

// File: rtl/sine_dds_gen.sv
// Quarter-wave DDS sine/cosine generator: phase accumulator, fold, ROM read, sign apply.
// Three registered stages (fold, ROM, sign); each stage loads only behind a valid sample.
module sine_dds_gen #(
   parameter int PHASE_W = 32,
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 16,
   parameter bit QUAD    = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   sine_dds_gen_if.slave bus
);
   localparam int                N  = 2 ** ADDR_W;
   localparam logic [DATA_W-2:0] FS = '1;

   function automatic logic [DATA_W-2:0] tab_val(input int k);
      real r;
      int  v;
      r = (2.0 ** (DATA_W - 1) - 1.0) * $sin(3.141592653589793 / 2.0 * real'(k) / real'(N));
      v = $rtoi(r + 0.5);
      return v[DATA_W-2:0];
   endfunction

   logic [DATA_W-2:0] rom [N];

   for (genvar g = 0; g < N; g++) begin : g_rom
      assign rom[g] = tab_val(g);
   end

   logic [PHASE_W-1:0]       acc;
   logic [PHASE_W-1:0]       phase;
   logic [1:0]               qd;
   logic [ADDR_W-1:0]        q;
   logic [ADDR_W-1:0]        q_mir;
   logic                     v1, v2, v3;
   logic [ADDR_W-1:0]        s1_addr;
   logic                     s1_peak, s1_neg;
   logic [DATA_W-2:0]        s2_mag;
   logic                     s2_neg;
   logic signed [DATA_W-1:0] sin_r, cos_r;

   // A clear launches its sample at phase_ofs, as if the accumulator already read zero.
   always_comb begin
      phase = (bus.phase_clr ? '0 : acc) + bus.phase_ofs;
      qd    = phase[PHASE_W-1 -: 2];
      q     = phase[PHASE_W-3 -: ADDR_W];
      q_mir = '0 - q;
   end

   if (PHASE_W > ADDR_W + 2) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^phase[PHASE_W-ADDR_W-3:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         v1      <= 1'b0;
         v2      <= 1'b0;
         v3      <= 1'b0;
         s1_addr <= '0;
         s1_peak <= 1'b0;
         s1_neg  <= 1'b0;
         s2_mag  <= '0;
         s2_neg  <= 1'b0;
         sin_r   <= '0;
      end else begin
         // An enabled clear consumes phase zero, so the accumulator steps straight past it.
         if (bus.phase_clr)
            acc <= bus.en ? bus.freq_word : '0;
         else if (bus.en)
            acc <= acc + bus.freq_word;
         v1 <= bus.en;
         v2 <= v1;
         v3 <= v2;
         if (bus.en) begin
            s1_addr <= qd[0] ? q_mir : q;
            s1_peak <= qd[0] && (q == '0);
            s1_neg  <= qd[1];
         end
         if (v1) begin
            s2_mag <= s1_peak ? FS : rom[s1_addr];
            s2_neg <= s1_neg;
         end
         if (v2)
            sin_r <= s2_neg ? -$signed({1'b0, s2_mag}) : $signed({1'b0, s2_mag});
      end
   end

   // Cosine is the sine a quarter turn ahead: mirror on even quadrants, negative in 1 and 2.
   if (QUAD) begin : g_cos
      logic [ADDR_W-1:0] c1_addr;
      logic              c1_peak, c1_neg;
      logic [DATA_W-2:0] c2_mag;
      logic              c2_neg;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            c1_addr <= '0;
            c1_peak <= 1'b0;
            c1_neg  <= 1'b0;
            c2_mag  <= '0;
            c2_neg  <= 1'b0;
            cos_r   <= '0;
         end else begin
            if (bus.en) begin
               c1_addr <= qd[0] ? q : q_mir;
               c1_peak <= !qd[0] && (q == '0);
               c1_neg  <= qd[1] ^ qd[0];
            end
            if (v1) begin
               c2_mag <= c1_peak ? FS : rom[c1_addr];
               c2_neg <= c1_neg;
            end
            if (v2)
               cos_r <= c2_neg ? -$signed({1'b0, c2_mag}) : $signed({1'b0, c2_mag});
         end
      end
   end else begin : g_nocos
      assign cos_r = '0;
   end

   assign bus.sin_out   = sin_r;
   assign bus.cos_out   = cos_r;
   assign bus.out_valid = v3;
endmodule
